// File: rtl/tick_digit_counter_pkg.sv
// Shared types and active-low 7-segment glyphs (bit order gfedcba) for the display chain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tick_digit_counter_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/tick_digit_counter_if.sv
// Bundles the divider inputs, digit controls and display outputs of the tick/digit stage.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level/strobe, no handshake.
interface tick_digit_counter_if #(
    parameter int RATE_W  = 27,
    parameter int DIGIT_W = 4
);
    logic [RATE_W-1:0]  rate;
    logic [RATE_W-1:0]  counterout;
    logic               enable;
    logic               up;
    logic               load;
    logic [DIGIT_W-1:0] load_val;
    logic               tick;
    logic [DIGIT_W-1:0] digit;
    logic               wrap;
    logic [6:0]         hex;

    modport master (
        output rate, counterout, enable, up, load, load_val,
        input  tick, digit, wrap, hex
    );

    modport slave (
        input  rate, counterout, enable, up, load, load_val,
        output tick, digit, wrap, hex
    );
endinterface

// File: rtl/tick_digit_counter_hex_decoder.sv
// 4-bit value to active-low 7-segment glyph (0-9, A b C d E F).
// Latency: combinational. Backpressure: none.
module hex_decoder
    import tick_digit_counter_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (val)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/tick_digit_counter.sv
// Divider terminal-count tick driving a bounded up/down digit with load, run/stop FSM and hex display.
// Latency: match -> tick +1 cycle -> digit/wrap +1 cycle; load -> digit +1 cycle; hex combinational from digit.
// Backpressure: none; free-running, every tick is consumed in the cycle it is presented.
module tick_digit_counter
    import tick_digit_counter_pkg::*;
#(
    parameter int RATE_W  = 27,
    parameter int DIGIT_W = 4,
    parameter int MAX_VAL = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    tick_digit_counter_if.slave  bus
);
    localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_VAL);

    logic               tick_d,  tick_q;
    state_t             state_d, state_q;
    logic               run;
    logic [DIGIT_W-1:0] digit_d, digit_q;
    logic               wrap_d,  wrap_q;
    logic [3:0]         dec_in;
    logic [6:0]         dec_seg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_q  <= 1'b0;
            state_q <= STOPPED;
            digit_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            state_q <= state_d;
            digit_q <= digit_d;
            wrap_q  <= wrap_d;
        end
    end

    // Full-width compare against whatever rate is current; rate 0 yields a tick every cycle.
    always_comb begin
        tick_d = (RATE_W'(bus.counterout) == RATE_W'(bus.rate));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STOPPED: if (bus.enable)  state_d = RUNNING;
            RUNNING: if (!bus.enable) state_d = STOPPED;
            default: state_d = STOPPED;
        endcase
    end

    always_comb begin
        run = (state_q == RUNNING);
    end

    // Load wins over a same-cycle tick, which is then dropped without counting.
    always_comb begin
        digit_d = digit_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            digit_d = (bus.load_val > MAX_D) ? MAX_D : bus.load_val;
        end else if (run && tick_q) begin
            if (bus.up) begin
                if (digit_q == MAX_D) begin
                    digit_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    digit_d = digit_q + DIGIT_W'(1);
                end
            end else begin
                if (digit_q == '0) begin
                    digit_d = MAX_D;
                    wrap_d  = 1'b1;
                end else begin
                    digit_d = digit_q - DIGIT_W'(1);
                end
            end
        end
    end

    always_comb begin
        dec_in = 4'(digit_q);
    end

    hex_decoder u_hex_decoder (
        .val (dec_in),
        .seg (dec_seg)
    );

    assign bus.tick  = tick_q;
    assign bus.digit = digit_q;
    assign bus.wrap  = wrap_q;
    assign bus.hex   = (32'(digit_q) > 32'd15) ? SEG_BLANK : dec_seg;

endmodule

// File: doc/tick_digit_counter.md
Name: tick_digit_counter

Overview:
- Sits directly downstream of the rate divider. Watches the divider's count against the same rate value and turns each terminal count into a registered one-cycle tick.
- Each tick advances a single bounded digit (up or down, with wrap and parallel load), gated by a run/stop state machine.
- Drives the digit onto an active-low 7-segment display, as used on the board's HEX outputs.

Parameters:
- RATE_W, 27, width of the rate and counterout buses; matches the divider (max rate 50,000,000).
- DIGIT_W, 4, width of the counted digit.
- MAX_VAL, 15, highest digit value; the wrap point. Must satisfy 1 <= MAX_VAL <= 2^DIGIT_W-1.

Ports:
- clk  in  1  CLOCK_50, the same clock as the divider.
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clk.
- rate  in  RATE_W  the rate value also driving the divider.
- counterout  in  RATE_W  the divider's count output.
- enable  in  1  1 = run, 0 = stop.
- up  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous parallel-load strobe.
- load_val  in  DIGIT_W  value to load.
- tick  out  1  registered one-cycle pulse, one per divider period.
- digit  out  DIGIT_W  current digit.
- wrap  out  1  one-cycle pulse on the cycle digit wraps.
- hex  out  7  segment pattern for digit, active-low, bit order gfedcba.

Behaviour:
- Reset (reset==0 at posedge) has priority over everything:
  - tick=0, wrap=0, digit=0, state=STOPPED.
  - hex shows "0" (7'b1000000) from the next cycle on.
- Tick generation:
  - tick <= (counterout == rate), full RATE_W compare, registered.
  - Equality at cycle N gives tick high at cycle N+1 for exactly one cycle per match.
  - rate==0: the divider sits at 0, so tick stays high every cycle. This is legal and is not filtered.
  - rate changed mid-count: compare against the current rate only. There is no extra state.
- State machine, two states:
  - STOPPED -> RUNNING when enable==1.
  - RUNNING -> STOPPED when enable==0.
  - Transitions are registered. Counting uses the current (registered) state, so a tick in the same cycle enable first rises is ignored.
- Digit update at each posedge, in priority order:
  1. reset.
  2. load==1: digit <= min(load_val, MAX_VAL). Applies in either state. Any concurrent tick is consumed with no count and wrap=0.
  3. state==RUNNING && tick==1 && up==1: digit==MAX_VAL ? 0 with wrap=1 : digit+1.
  4. state==RUNNING && tick==1 && up==0: digit==0 ? MAX_VAL with wrap=1 : digit-1.
  5. Otherwise digit holds.
- wrap is 0 on every cycle not covered by rules 3 or 4.
- Latency:
  - counterout==rate at cycle N -> tick at N+1 -> digit and wrap updated at N+2.
  - load at N -> digit valid at N+1.
- Arithmetic is DIGIT_W wide. No value outside 0..MAX_VAL is ever stored.
- up may change at any cycle; it is sampled together with tick.
- hex is a combinational decode of the registered digit:
  - 0-9 as decimal glyphs.
  - A, b, C, d, E, F for 10-15.
  - Values above 15 are unreachable at DIGIT_W=4.

Decomposition:
- Shared package:
  - state enum {STOPPED, RUNNING}.
  - Segment pattern constants SEG_0..SEG_F (active-low).
  - SEG_BLANK = 7'b1111111.
- One sub-module, hex_decoder: 4-bit in, 7-bit active-low out, purely combinational. Reused by the other display stages.

Test Plan:
- Reset: hold reset=0 for 3 cycles with tick-causing inputs present -> tick=0, wrap=0, digit=0, hex=7'b1000000. Release and hold enable=0 with counterout==rate -> digit stays 0 while tick still pulses.
- Tick timing: rate=4, counterout sweeping 0..4 repeatedly, enable=1, up=1 -> tick high on the cycle after each counterout==4, every 5 cycles. Digit increments 2 cycles after each match.
- Up wrap: load_val=13, load one cycle, then 3 ticks with up=1 -> digit 14, 15, 0, with wrap high only on the 15->0 cycle.
- Down wrap and clamp:
  - With MAX_VAL=9 build: load_val=12 -> digit=9.
  - Ticks with up=0 -> 8..0, then 0->9 with wrap=1 and hex=SEG_9.
- Simultaneous events:
  - load=1 with tick=1 -> digit=load_val, wrap=0.
  - enable rising on the same cycle as a tick -> no count. The next tick counts.
- Mid-operation reset and rate 0:
  - rate=0, enable=1 -> digit advances every cycle.
  - Assert reset at digit=7 -> digit=0 next cycle, state STOPPED, so one further cycle of enable=1 passes before counting resumes.
